cpu_controller: RTL and testbench
=================================

Name: cpu_controller

Overview:
Upstream control stage for the datapath. It fetches 16-bit instructions from memory into an instruction register (IR), decodes them, and runs a Moore FSM that drives every datapath control input: readnum, writenum, write, vsel, asel, bsel, loada, loadb, loadc, loads, ALUop and shift. It also drives the sign-extended immediate and the PC. It owns the PC and the data-address register (DA), and issues memory commands for fetch, LDR and STR.

Parameters:
ADDR_W, 8, width of PC, DA and mem_addr
RESET_PC, 8'h00, PC value loaded on reset

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
mem_rdata  in  16  memory read data (instruction or load data), valid the cycle after the address is presented
c_in  in  16  datapath C register output (datapath_out)
mem_cmd  out  2  `MNONE / `MREAD / `MWRITE
mem_addr  out  ADDR_W  PC during fetch, DA during LDR/STR
sximm8  out  16  {{8{IR[7]}}, IR[7:0]} to datapath_in
PC  out  ADDR_W  program counter to datapath PC input
readnum, writenum  out  3 each  register-file indices
write, loada, loadb, loadc, loads, asel, bsel  out  1 each  datapath strobes and selects
vsel, ALUop, shift  out  2 each  datapath selects
halted  out  1  high in HALT state

Behaviour:
- Reset (async, reset_n=0): state=RST, PC=RESET_PC, IR=0, DA=0. All outputs 0, mem_cmd=`MNONE. A reset asserted mid-instruction abandons it immediately; no partial writes occur after the reset edge.
- Outputs are combinational from state and IR only (Moore). Any output not listed for a state is 0.
- IR fields: opcode=IR[15:13], op=IR[12:11], Rn=IR[10:8], Rd=IR[7:5], sh=IR[4:3], Rm=IR[2:0].
- Fetch sequence: RST -> IF1 -> IF2 -> UPD_PC -> DECODE.
  - IF1 and IF2: mem_addr=PC, mem_cmd=`MREAD.
  - IR <= mem_rdata at the end of IF2.
  - UPD_PC: PC <= PC+1, wrapping modulo 2^ADDR_W (8'hFF -> 8'h00).
- DECODE dispatches on {opcode, op}:
  - 110_10 MOV imm: WR_IMM (vsel=`SXIMM8, writenum=Rn, write=1) -> IF1.
  - 110_00 MOV reg: GET_B -> ALU -> WR_REG.
  - 101_00 ADD, 101_10 AND: GET_A -> GET_B -> ALU -> WR_REG.
  - 101_01 CMP: GET_A -> GET_B -> CMP -> IF1.
  - 101_11 MVN: GET_B -> ALU -> WR_REG.
  - 011_00 LDR: GET_A -> ADDR -> LD_DA -> MEM_RD -> WR_MEM -> IF1.
  - 100_00 STR: GET_A -> ADDR -> LD_DA -> GET_STR -> STR_C -> MEM_WR -> IF1.
  - 111_xx HALT, and every other encoding: HALT.
- State outputs:
  - GET_A: readnum=Rn, loada=1.
  - GET_B: readnum=Rm, loadb=1.
  - ALU: shift=sh, loadc=1, asel=1 for MOV reg and MVN (else 0), bsel=0, ALUop=op (MOV reg uses 00).
  - CMP: shift=sh, ALUop=01, loads=1.
  - WR_REG: vsel=`C, writenum=Rd, write=1 -> IF1.
  - ADDR: asel=0, bsel=1, ALUop=00, loadc=1.
  - LD_DA: DA <= c_in[ADDR_W-1:0].
  - MEM_RD: mem_addr=DA, mem_cmd=`MREAD.
  - WR_MEM: mem_addr=DA, mem_cmd=`MREAD, vsel=`MDATA, writenum=Rd, write=1.
  - GET_STR: readnum=Rd, loadb=1.
  - STR_C: asel=1, bsel=0, shift=00, ALUop=00, loadc=1.
  - MEM_WR: mem_addr=DA, mem_cmd=`MWRITE; memory write data is c_in.
- HALT: halted=1, mem_cmd=`MNONE, PC frozen. Only reset_n exits HALT.
- Latency in cycles, including 4 cycles of fetch and decode:
  - MOV imm: 5
  - MVN, MOV reg: 7
  - ADD, AND: 8
  - CMP: 7
  - LDR: 9
  - STR: 10
- write and mem_cmd=`MWRITE are each asserted for exactly one cycle per instruction.

Decomposition:
- constants.v holds the shared encodings:
  - vsel: `C=2'b00, `PC=2'b01, `SXIMM8=2'b10, `MDATA=2'b11.
  - mem_cmd: `MNONE=2'b00, `MREAD=2'b01, `MWRITE=2'b10.
  - Opcode and state encodings also live in constants.v.
- One sub-module, instr_decoder: combinational IR field split plus sximm8 generation.
- The FSM, PC, IR and DA registers stay in cpu_controller.

Test Plan:
- Reset mid-ADD (assert reset_n=0 in the ALU state) -> next cycle state=RST, PC=0, write=0, mem_cmd=`MNONE.
- mem_rdata=16'hD205 (MOV R2,#5) -> in cycle 5, vsel=`SXIMM8, writenum=2, write=1, sximm8=16'h0005, and PC=1 afterwards. With IR[7:0]=8'hFB, sximm8=16'hFFFB.
- ADD R3,R1,R2 LSL#1 (16'hA16A) -> GET_A readnum=1; GET_B readnum=2; ALU shift=01, ALUop=00; WR_REG writenum=3. Exactly 8 cycles.
- LDR R4,[R1,#3] (16'h6183) with c_in=16'h0013 at LD_DA -> mem_addr=8'h13 in MEM_RD and WR_MEM, vsel=`MDATA, writenum=4.
- STR R5,[R0,#1] (16'h80A1) -> GET_STR readnum=5, STR_C asel=1, one MEM_WR cycle with mem_cmd=`MWRITE and mem_addr=DA.
- PC=8'hFF fetching HALT 16'hE000 -> PC wraps to 8'h00, halted=1 persists for 20 cycles, mem_cmd=`MNONE throughout.

Source files
------------

// File: rtl/cpu_controller_pkg.sv
// Shared encodings for the CPU control stage: datapath select codes,
// memory commands, {opcode,op} dispatch keys, FSM states and IR field helpers.
package cpu_controller_pkg;

  // vsel encodings (writeback source select into the register file)
  localparam logic [1:0] VSEL_C      = 2'b00;
  localparam logic [1:0] VSEL_PC     = 2'b01;
  localparam logic [1:0] VSEL_SXIMM8 = 2'b10;
  localparam logic [1:0] VSEL_MDATA  = 2'b11;

  // Memory command encodings
  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  // Dispatch keys: {opcode[2:0], op[1:0]}
  localparam logic [4:0] OPC_MOV_IMM = 5'b110_10;
  localparam logic [4:0] OPC_MOV_REG = 5'b110_00;
  localparam logic [4:0] OPC_ADD     = 5'b101_00;
  localparam logic [4:0] OPC_CMP     = 5'b101_01;
  localparam logic [4:0] OPC_AND     = 5'b101_10;
  localparam logic [4:0] OPC_MVN     = 5'b101_11;
  localparam logic [4:0] OPC_LDR     = 5'b011_00;
  localparam logic [4:0] OPC_STR     = 5'b100_00;

  // Controller FSM states
  typedef enum logic [4:0] {
    ST_RST     = 5'd0,
    ST_IF1     = 5'd1,
    ST_IF2     = 5'd2,
    ST_UPD_PC  = 5'd3,
    ST_DECODE  = 5'd4,
    ST_WR_IMM  = 5'd5,
    ST_GET_A   = 5'd6,
    ST_GET_B   = 5'd7,
    ST_ALU     = 5'd8,
    ST_CMP     = 5'd9,
    ST_WR_REG  = 5'd10,
    ST_ADDR    = 5'd11,
    ST_LD_DA   = 5'd12,
    ST_MEM_RD  = 5'd13,
    ST_WR_MEM  = 5'd14,
    ST_GET_STR = 5'd15,
    ST_STR_C   = 5'd16,
    ST_MEM_WR  = 5'd17,
    ST_HALT    = 5'd18
  } state_t;

  // Sign-extend the 8-bit immediate field to datapath width
  function automatic logic [15:0] sext8(input logic [7:0] imm);
    return {{8{imm[7]}}, imm};
  endfunction

endpackage

// File: rtl/cpu_controller_instr_decoder.sv
// Combinational instruction-register field split and immediate extension.
module instr_decoder
  import cpu_controller_pkg::*;
(
  input  logic [15:0] i_ir,
  output logic [2:0]  o_opcode,
  output logic [1:0]  o_op,
  output logic [2:0]  o_rn,
  output logic [2:0]  o_rd,
  output logic [1:0]  o_sh,
  output logic [2:0]  o_rm,
  output logic [15:0] o_sximm8
);

  // Slice the fixed IR fields and sign-extend the low byte
  always_comb begin
    o_opcode = i_ir[15:13];
    o_op     = i_ir[12:11];
    o_rn     = i_ir[10:8];
    o_rd     = i_ir[7:5];
    o_sh     = i_ir[4:3];
    o_rm     = i_ir[2:0];
    o_sximm8 = sext8(i_ir[7:0]);
  end

endmodule

// File: rtl/cpu_controller.sv
// Control stage: fetches instructions into IR, decodes them and sequences
// the datapath through a Moore FSM. Owns PC and the data-address register.
module cpu_controller
  import cpu_controller_pkg::*;
#(
  parameter int                 ADDR_W   = 8,
  parameter logic [ADDR_W-1:0]  RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [15:0]       mem_rdata,
  input  logic [15:0]       c_in,
  output logic [1:0]        mem_cmd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       sximm8,
  output logic [ADDR_W-1:0] PC,
  output logic [2:0]        readnum,
  output logic [2:0]        writenum,
  output logic              write,
  output logic              loada,
  output logic              loadb,
  output logic              loadc,
  output logic              loads,
  output logic              asel,
  output logic              bsel,
  output logic [1:0]        vsel,
  output logic [1:0]        ALUop,
  output logic [1:0]        shift,
  output logic              halted
);

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [15:0]       r_ir;
  logic [ADDR_W-1:0] r_da;

  logic [2:0]        w_opcode;
  logic [1:0]        w_op;
  logic [2:0]        w_rn;
  logic [2:0]        w_rd;
  logic [1:0]        w_sh;
  logic [2:0]        w_rm;
  logic [4:0]        w_opc;
  logic              w_unused_c_in;

  instr_decoder u_decoder (
    .i_ir     (r_ir),
    .o_opcode (w_opcode),
    .o_op     (w_op),
    .o_rn     (w_rn),
    .o_rd     (w_rd),
    .o_sh     (w_sh),
    .o_rm     (w_rm),
    .o_sximm8 (sximm8)
  );

  assign w_opc = {w_opcode, w_op};
  assign PC    = r_pc;

  // Only the low address bits of the datapath result form a data address
  assign w_unused_c_in = ^c_in[15:ADDR_W];

  // State sequencing plus the PC, IR and DA registers
  // NOTE: every register here uses <= so all updates in one edge see the
  // pre-edge values; blocking assignments would make order matter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_RST;
      r_pc    <= RESET_PC;
      r_ir    <= 16'h0000;
      r_da    <= {ADDR_W{1'b0}};
    end else begin
      case (r_state)
        ST_RST:    r_state <= ST_IF1;
        ST_IF1:    r_state <= ST_IF2;
        ST_IF2: begin
          r_ir    <= mem_rdata;
          r_state <= ST_UPD_PC;
        end
        ST_UPD_PC: begin
          r_pc    <= r_pc + ADDR_W'(1);
          r_state <= ST_DECODE;
        end
        ST_DECODE: begin
          case (w_opc)
            OPC_MOV_IMM:          r_state <= ST_WR_IMM;
            OPC_MOV_REG, OPC_MVN: r_state <= ST_GET_B;
            OPC_ADD, OPC_AND, OPC_CMP,
            OPC_LDR, OPC_STR:     r_state <= ST_GET_A;
            default:              r_state <= ST_HALT;
          endcase
        end
        ST_WR_IMM: r_state <= ST_IF1;
        ST_GET_A: begin
          if (w_opc == OPC_LDR || w_opc == OPC_STR) r_state <= ST_ADDR;
          else                                      r_state <= ST_GET_B;
        end
        ST_GET_B: begin
          if (w_opc == OPC_CMP) r_state <= ST_CMP;
          else                  r_state <= ST_ALU;
        end
        ST_ALU:    r_state <= ST_WR_REG;
        ST_CMP:    r_state <= ST_IF1;
        ST_WR_REG: r_state <= ST_IF1;
        ST_ADDR:   r_state <= ST_LD_DA;
        ST_LD_DA: begin
          r_da <= c_in[ADDR_W-1:0];
          if (w_opc == OPC_STR) r_state <= ST_GET_STR;
          else                  r_state <= ST_MEM_RD;
        end
        ST_MEM_RD:  r_state <= ST_WR_MEM;
        ST_WR_MEM:  r_state <= ST_IF1;
        ST_GET_STR: r_state <= ST_STR_C;
        ST_STR_C:   r_state <= ST_MEM_WR;
        ST_MEM_WR:  r_state <= ST_IF1;
        ST_HALT:    r_state <= ST_HALT;
        default:    r_state <= ST_RST;
      endcase
    end
  end

  // Moore output decode from state and IR fields
  always_comb begin
    // NOTE: every output gets a default before the case so states that do
    // not mention a signal drive 0 instead of inferring a latch.
    mem_cmd  = MEM_NONE;
    mem_addr = {ADDR_W{1'b0}};
    readnum  = 3'd0;
    writenum = 3'd0;
    write    = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    vsel     = VSEL_C;
    ALUop    = 2'b00;
    shift    = 2'b00;
    halted   = 1'b0;
    case (r_state)
      ST_IF1, ST_IF2: begin
        mem_cmd  = MEM_READ;
        mem_addr = r_pc;
      end
      ST_WR_IMM: begin
        vsel     = VSEL_SXIMM8;
        writenum = w_rn;
        write    = 1'b1;
      end
      ST_GET_A: begin
        readnum = w_rn;
        loada   = 1'b1;
      end
      ST_GET_B: begin
        readnum = w_rm;
        loadb   = 1'b1;
      end
      ST_ALU: begin
        shift = w_sh;
        loadc = 1'b1;
        // Single-operand ops route a zero A input so B passes through
        asel  = (w_opc == OPC_MOV_REG) || (w_opc == OPC_MVN);
        ALUop = (w_opc == OPC_MOV_REG) ? 2'b00 : w_op;
      end
      ST_CMP: begin
        shift = w_sh;
        ALUop = 2'b01;
        loads = 1'b1;
      end
      ST_WR_REG: begin
        vsel     = VSEL_C;
        writenum = w_rd;
        write    = 1'b1;
      end
      ST_ADDR: begin
        bsel  = 1'b1;
        loadc = 1'b1;
      end
      ST_MEM_RD: begin
        mem_cmd  = MEM_READ;
        mem_addr = r_da;
      end
      ST_WR_MEM: begin
        mem_cmd  = MEM_READ;
        mem_addr = r_da;
        vsel     = VSEL_MDATA;
        writenum = w_rd;
        write    = 1'b1;
      end
      ST_GET_STR: begin
        readnum = w_rd;
        loadb   = 1'b1;
      end
      ST_STR_C: begin
        asel  = 1'b1;
        loadc = 1'b1;
      end
      ST_MEM_WR: begin
        mem_cmd  = MEM_WRITE;
        mem_addr = r_da;
      end
      ST_HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Self-checking bench for cpu_controller. A reference model of the
// instruction sequences pushes one expected output vector per cycle into a
// scoreboard queue; the DUT outputs are popped and compared each cycle.
module tb_cpu_controller;

  typedef struct packed {
    logic [1:0]  mem_cmd;
    logic [7:0]  mem_addr;
    logic [7:0]  pc;
    logic [15:0] sximm8;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic        bsel;
    logic [1:0]  vsel;
    logic [1:0]  aluop;
    logic [1:0]  shift;
    logic        halted;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] mem_rdata = 16'h0000;
  logic [15:0] c_in = 16'h0000;
  logic [1:0]  mem_cmd;
  logic [7:0]  mem_addr;
  logic [15:0] sximm8;
  logic [7:0]  PC;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic        write, loada, loadb, loadc, loads, asel, bsel;
  logic [1:0]  vsel, ALUop, shift;
  logic        halted;

  always #5 clk = ~clk;

  cpu_controller dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .mem_rdata (mem_rdata),
    .c_in      (c_in),
    .mem_cmd   (mem_cmd),
    .mem_addr  (mem_addr),
    .sximm8    (sximm8),
    .PC        (PC),
    .readnum   (readnum),
    .writenum  (writenum),
    .write     (write),
    .loada     (loada),
    .loadb     (loadb),
    .loadc     (loadc),
    .loads     (loads),
    .asel      (asel),
    .bsel      (bsel),
    .vsel      (vsel),
    .ALUop     (ALUop),
    .shift     (shift),
    .halted    (halted)
  );

  vec_t obs;
  always_comb begin
    obs          = '0;
    obs.mem_cmd  = mem_cmd;
    obs.mem_addr = mem_addr;
    obs.pc       = PC;
    obs.sximm8   = sximm8;
    obs.readnum  = readnum;
    obs.writenum = writenum;
    obs.write    = write;
    obs.loada    = loada;
    obs.loadb    = loadb;
    obs.loadc    = loadc;
    obs.loads    = loads;
    obs.asel     = asel;
    obs.bsel     = bsel;
    obs.vsel     = vsel;
    obs.aluop    = ALUop;
    obs.shift    = shift;
    obs.halted   = halted;
  end

  vec_t        sb[$];
  int          total = 0;
  int          bad = 0;
  logic [7:0]  m_pc = 8'h00;
  logic [15:0] m_ir = 16'h0000;
  logic [7:0]  m_da = 8'h00;

  // Idle vector for the current model PC/IR: every strobe low
  function automatic vec_t base();
    vec_t v;
    v        = '0;
    v.pc     = m_pc;
    v.sximm8 = {{8{m_ir[7]}}, m_ir[7:0]};
    return v;
  endfunction

  // Push the full expected cycle sequence of one instruction
  task automatic build_instr(input logic [15:0] instr, input logic [15:0] cval);
    vec_t v;
    logic [4:0] k;
    logic [1:0] op, sh;
    logic [2:0] rn, rd, rm;
    k  = instr[15:11];
    op = instr[12:11];
    rn = instr[10:8];
    rd = instr[7:5];
    sh = instr[4:3];
    rm = instr[2:0];
    v = base(); v.mem_cmd = 2'b01; v.mem_addr = m_pc;
    sb.push_back(v);
    sb.push_back(v);
    m_ir = instr;
    sb.push_back(base());
    m_pc = m_pc + 8'd1;
    sb.push_back(base());
    if (k == 5'b11010) begin
      v = base(); v.vsel = 2'b10; v.writenum = rn; v.write = 1'b1;
      sb.push_back(v);
    end else if (k == 5'b11000 || k == 5'b10100 || k == 5'b10101 ||
                 k == 5'b10110 || k == 5'b10111) begin
      if (k == 5'b10100 || k == 5'b10101 || k == 5'b10110) begin
        v = base(); v.readnum = rn; v.loada = 1'b1;
        sb.push_back(v);
      end
      v = base(); v.readnum = rm; v.loadb = 1'b1;
      sb.push_back(v);
      if (k == 5'b10101) begin
        v = base(); v.shift = sh; v.aluop = 2'b01; v.loads = 1'b1;
        sb.push_back(v);
      end else begin
        v = base(); v.shift = sh; v.loadc = 1'b1;
        v.asel  = (k == 5'b11000) || (k == 5'b10111);
        v.aluop = (k == 5'b11000) ? 2'b00 : op;
        sb.push_back(v);
        v = base(); v.vsel = 2'b00; v.writenum = rd; v.write = 1'b1;
        sb.push_back(v);
      end
    end else if (k == 5'b01100 || k == 5'b10000) begin
      v = base(); v.readnum = rn; v.loada = 1'b1;
      sb.push_back(v);
      v = base(); v.bsel = 1'b1; v.loadc = 1'b1;
      sb.push_back(v);
      sb.push_back(base());
      m_da = cval[7:0];
      if (k == 5'b01100) begin
        v = base(); v.mem_cmd = 2'b01; v.mem_addr = m_da;
        sb.push_back(v);
        v.vsel = 2'b11; v.writenum = rd; v.write = 1'b1;
        sb.push_back(v);
      end else begin
        v = base(); v.readnum = rd; v.loadb = 1'b1;
        sb.push_back(v);
        v = base(); v.asel = 1'b1; v.loadc = 1'b1;
        sb.push_back(v);
        v = base(); v.mem_cmd = 2'b10; v.mem_addr = m_da;
        sb.push_back(v);
      end
    end
  endtask

  task automatic push_halt(input int n);
    vec_t v;
    for (int j = 0; j < n; j++) begin
      v = base(); v.halted = 1'b1;
      sb.push_back(v);
    end
  endtask

  // Scoreboard consumer: pop one vector per cycle and compare (n<0: all)
  task automatic drain(input string tag, input int n);
    vec_t exp;
    int   i;
    i = 0;
    while (sb.size() > 0 && (n < 0 || i < n)) begin
      exp = sb.pop_front();
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL %s step %0d: got %h expected %h", tag, i, obs, exp);
      end
      i++;
      @(negedge clk);
    end
  endtask

  task automatic run_instr(input logic [15:0] instr, input logic [15:0] cval,
                           input string tag);
    mem_rdata = instr;
    c_in      = cval;
    build_instr(instr, cval);
    drain(tag, -1);
  endtask

  // Pulse reset and leave the DUT in IF1 at a falling edge
  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0;
    m_pc = 8'h00; m_ir = 16'h0000; m_da = 8'h00;
    sb.delete();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    vec_t exp;
    repeat (2) @(negedge clk);
    exp = base();
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL reset_state: got %h expected %h", obs, exp);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mov_imm();
    run_instr(16'hD205, 16'h0000, "mov_imm_pos");
    total++;
    if (PC !== 8'h01) begin
      bad++;
      $display("FAIL mov_imm_pc: got %h expected 01", PC);
    end
    run_instr(16'hD3FB, 16'h0000, "mov_imm_neg");
  endtask

  task automatic test_alu_ops();
    run_instr(16'hA16A, 16'h0000, "add");
    run_instr(16'hB2E3, 16'h0000, "and");
    run_instr(16'hB8B1, 16'h0000, "mvn");
    run_instr(16'hA90A, 16'h0000, "cmp");
    run_instr(16'hC0CD, 16'h0000, "mov_reg");
  endtask

  task automatic test_ldr_str();
    run_instr(16'h6183, 16'h0013, "ldr");
    run_instr(16'h80A1, 16'h0042, "str");
    run_instr(16'h6183, 16'h01F7, "ldr_hi");
  endtask

  task automatic test_back_to_back();
    logic [4:0]  keys [8];
    logic [31:0] r;
    logic [15:0] instr;
    logic [15:0] cval;
    keys = '{5'b11010, 5'b11000, 5'b10100, 5'b10110,
             5'b10101, 5'b10111, 5'b01100, 5'b10000};
    apply_reset();
    for (int n = 0; n < 24; n++) begin
      r     = $urandom();
      instr = {keys[$urandom_range(0, 7)], r[10:0]};
      cval  = r[31:16];
      run_instr(instr, cval, "b2b");
    end
  endtask

  task automatic test_reset_mid_add();
    vec_t exp;
    apply_reset();
    run_instr(16'hD101, 16'h0000, "pre_add");
    mem_rdata = 16'hA16A;
    build_instr(16'hA16A, 16'h0000);
    drain("mid_add", 6);
    exp = sb.pop_front();
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL mid_add_alu: got %h expected %h", obs, exp);
    end
    sb.delete();
    reset_n = 1'b0;
    m_pc = 8'h00; m_ir = 16'h0000; m_da = 8'h00;
    #1;
    exp = base();
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL mid_add_reset_now: got %h expected %h", obs, exp);
    end
    @(posedge clk);
    #1;
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL mid_add_reset_next: got %h expected %h", obs, exp);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run_instr(16'hD407, 16'h0000, "post_reset");
  endtask

  task automatic test_illegal();
    apply_reset();
    mem_rdata = 16'hC800;
    build_instr(16'hC800, 16'h0000);
    push_halt(3);
    drain("illegal", -1);
  endtask

  task automatic test_halt_wrap();
    logic [31:0] r;
    apply_reset();
    for (int n = 0; n < 255; n++) begin
      r = $urandom();
      run_instr({5'b11010, r[10:0]}, 16'h0000, "fill");
    end
    total++;
    if (PC !== 8'hFF) begin
      bad++;
      $display("FAIL wrap_pc_before: got %h expected ff", PC);
    end
    mem_rdata = 16'hE000;
    build_instr(16'hE000, 16'h0000);
    push_halt(20);
    drain("halt_wrap", -1);
    total++;
    if (PC !== 8'h00 || halted !== 1'b1 || mem_cmd !== 2'b00) begin
      bad++;
      $display("FAIL halt_final: got pc=%h halted=%b cmd=%b expected 00/1/00",
               PC, halted, mem_cmd);
    end
  endtask

  initial begin
    test_reset();
    test_mov_imm();
    test_alu_ops();
    test_ldr_str();
    test_reset_mid_add();
    test_back_to_back();
    test_illegal();
    test_halt_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
